// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl - memory-stage load/store initiator.
//
// Accepts one load/store per transaction from the pipeline and drives a
// word-organised, byte-enabled data memory with a synchronous 1-cycle read.
// Halfword/word accesses that straddle a word boundary are split into two
// word accesses: word N then word N+1 (N+1 wraps at the top of memory).
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE; the requester holds its request (valid and
// payload stable) until it transfers. rsp_valid is a one-cycle completion
// pulse with no back-pressure; rsp_rdata is meaningful only in that cycle.
//
// Ports:
//   clk, rstn             clock (rising edge), synchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_we, req_type      1=store / width code (000 w, 001 h, 010 hu, 011 b, 100 bu)
//   req_addr, req_wdata   byte address, right-aligned store data
//   rsp_valid, rsp_rdata  completion pulse, extended load result (0 for stores)
//   mem_en/we/be/waddr/wdata  memory command (word index, lane-positioned data)
//   mem_rdata             word read in the previous cycle
//   dbg_state             current FSM state (IDLE=0, ACC0=1, ACC1=2, RESP=3)
module lsu_mem_ctrl #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_type,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-3:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [2:0] T_W  = 3'b000;
  localparam logic [2:0] T_H  = 3'b001;
  localparam logic [2:0] T_HU = 3'b010;
  localparam logic [2:0] T_B  = 3'b011;
  localparam logic [2:0] T_BU = 3'b100;

  state_t        r_state;
  state_t        w_next;
  logic          r_we;
  logic [2:0]    r_type;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_hold;

  logic          w_accept;
  logic [1:0]    w_off;
  logic [AW-3:0] w_word;
  logic          w_is_word;
  logic          w_is_half;
  logic          w_is_byte;
  logic          w_type_ok;
  logic          w_split;
  logic [3:0]    w_be_base;
  logic [3:0]    w_be0;
  logic [3:0]    w_be1;
  logic [5:0]    w_sh;
  logic [31:0]   w_wdata0;
  logic [31:0]   w_wdata1;
  logic [63:0]   w_cat;
  logic [31:0]   w_raw;
  logic [31:0]   w_ext;

  assign w_accept  = req_valid && req_ready;
  assign w_off     = r_addr[1:0];
  assign w_word    = r_addr[AW-1:2];
  assign w_is_word = (r_type == T_W);
  assign w_is_half = (r_type == T_H) || (r_type == T_HU);
  assign w_is_byte = (r_type == T_B) || (r_type == T_BU);
  assign w_type_ok = w_is_word || w_is_half || w_is_byte;
  assign w_split   = (w_is_half && (w_off == 2'd3)) || (w_is_word && (w_off != 2'd0));

  // Unshifted lane mask for the access width.
  always_comb begin
    w_be_base = 4'b0000;
    if (w_is_word)      w_be_base = 4'b1111;
    else if (w_is_half) w_be_base = 4'b0011;
    else if (w_is_byte) w_be_base = 4'b0001;
  end

  // First word takes the lanes shifted up by the offset (overflow lanes fall
  // off the top); the second word gets exactly those overflow lanes at the
  // bottom, which is the mask shifted down by (4 - off).
  assign w_sh     = {1'b0, w_off, 3'b000};
  assign w_be0    = w_be_base << w_off;
  assign w_be1    = w_be_base >> (3'd4 - {1'b0, w_off});
  assign w_wdata0 = r_wdata << w_sh;
  assign w_wdata1 = r_wdata >> (6'd32 - w_sh);

  // Load assembly: for a split access r_hold carries word N and mem_rdata
  // word N+1; otherwise mem_rdata alone carries word N.
  assign w_cat = w_split ? {mem_rdata, r_hold} : {32'h0, mem_rdata};
  assign w_raw = 32'(w_cat >> w_sh);

  always_comb begin
    w_ext = 32'h0;
    case (r_type)
      T_W:     w_ext = w_raw;
      T_H:     w_ext = {{16{w_raw[15]}}, w_raw[15:0]};
      T_HU:    w_ext = {16'h0, w_raw[15:0]};
      T_B:     w_ext = {{24{w_raw[7]}}, w_raw[7:0]};
      T_BU:    w_ext = {24'h0, w_raw[7:0]};
      default: w_ext = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_type  <= 3'b000;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_hold  <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_type  <= req_type;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == ACC1) r_hold <= mem_rdata;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'h0;
    mem_en    = 1'b0;
    mem_be    = 4'b0000;
    mem_waddr = '0;
    mem_wdata = 32'h0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = ACC0;
      end
      ACC0: begin
        if (w_type_ok) begin
          mem_en    = 1'b1;
          mem_be    = w_be0;
          mem_waddr = w_word;
          mem_wdata = w_wdata0;
        end
        w_next = (w_type_ok && w_split) ? ACC1 : RESP;
      end
      ACC1: begin
        mem_en    = 1'b1;
        mem_be    = w_be1;
        mem_waddr = w_word + 1'b1;
        mem_wdata = w_wdata1;
        w_next    = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (!r_we) rsp_rdata = w_ext;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Reset gates everything visible so no write or response leaks out of
    // a transaction cut short by reset.
    if (!rstn) begin
      w_next    = IDLE;
      rsp_valid = 1'b0;
      rsp_rdata = 32'h0;
      mem_en    = 1'b0;
      mem_be    = 4'b0000;
      mem_waddr = '0;
      mem_wdata = 32'h0;
    end
  end

  assign mem_we    = mem_en && r_we;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl: byte-level reference memory model, a TB-side
// word memory attached to the DUT port, and a scoreboard of expected load
// results and response cycles.
module tb_lsu_mem_ctrl;
  localparam int AW = 9;
  localparam int NB = 1 << AW;
  localparam int NW = NB / 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_type = 3'b000;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'h0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-3:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;
  logic [1:0]    dbg_state;

  lsu_mem_ctrl #(.AW(AW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory attached to the DUT ----------------
  logic [31:0] tb_mem [NW];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= tb_mem[mem_waddr];
      if (mem_we)
        for (int l = 0; l < 4; l++)
          if (mem_be[l]) tb_mem[mem_waddr][8*l +: 8] <= mem_wdata[8*l +: 8];
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [NB];

  task automatic ref_op(input bit we, input logic [2:0] typ, input logic [AW-1:0] addr,
                        input logic [31:0] wd, output logic [31:0] exp, output int lat);
    int nb;
    bit split;
    logic [31:0] raw;
    nb    = (typ == 3'd0) ? 4 : ((typ <= 3'd2) ? 2 : 1);
    split = (nb > 1) && ((int'(addr) % 4) + nb > 4);
    exp   = 32'h0;
    raw   = 32'h0;
    if (typ > 3'd4) begin
      lat = 2;
    end else begin
      lat = split ? 3 : 2;
      for (int i = 0; i < nb; i++) begin
        if (we) ref_mem[(int'(addr) + i) % NB] = wd[8*i +: 8];
        else    raw[8*i +: 8] = ref_mem[(int'(addr) + i) % NB];
      end
      if (!we) begin
        case (typ)
          3'd0: exp = raw;
          3'd1: exp = {{16{raw[15]}}, raw[15:0]};
          3'd2: exp = raw & 32'h0000FFFF;
          3'd3: exp = {{24{raw[7]}}, raw[7:0]};
          default: exp = raw & 32'h000000FF;
        endcase
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        int          ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check_val("rsp_rdata", rsp_rdata, e);
        check_val("rsp_cycle", 32'(cyc), 32'(ec));
      end
    end
  end

  // ---------------- driver ----------------
  // Returns at the negedge of the cycle after acceptance (ACC0 for valid types).
  task automatic do_req(input bit we, input logic [2:0] typ, input logic [AW-1:0] addr,
                        input logic [31:0] wd, input bit track, output int acc_cyc);
    int budget;
    logic [31:0] e;
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_type = typ; req_addr = addr; req_wdata = wd;
    budget = 0;
    while (!req_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) check_val("accept_timeout", 32'd0, 32'd1);
    acc_cyc = cyc;
    if (track) begin
      ref_op(we, typ, addr, wd, e, lat);
      exp_q.push_back(e);
      exp_cyc_q.push_back(acc_cyc + lat);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a0, a1, budget;
    for (int w = 0; w < NW; w++) tb_mem[w] = 32'h0;
    for (int b = 0; b < NB; b++) ref_mem[b] = 8'h00;

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_req_ready", 32'(req_ready), 32'd1);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_val("rst_mem_en", 32'(mem_en), 32'd0);
    check_val("rst_mem_be", 32'(mem_be), 32'd0);
    check_val("rst_mem_waddr", 32'(mem_waddr), 32'd0);
    rstn = 1'b1;

    // Aligned word store, then load back.
    do_req(1'b1, 3'd0, 9'h010, 32'hDEADBEEF, 1'b1, a0);
    check_val("sw_mem_en", 32'(mem_en), 32'd1);
    check_val("sw_mem_we", 32'(mem_we), 32'd1);
    check_val("sw_mem_be", 32'(mem_be), 32'hF);
    check_val("sw_waddr", 32'(mem_waddr), 32'd4);
    check_val("sw_wdata", mem_wdata, 32'hDEADBEEF);
    do_req(1'b0, 3'd0, 9'h010, 32'h0, 1'b1, a0);

    // Byte store with lane shift, signed and unsigned reloads.
    do_req(1'b1, 3'd3, 9'h006, 32'h00000082, 1'b1, a0);
    check_val("sb_mem_be", 32'(mem_be), 32'h4);
    check_val("sb_wdata", mem_wdata, 32'h00820000);
    do_req(1'b0, 3'd3, 9'h006, 32'h0, 1'b1, a0);
    do_req(1'b0, 3'd4, 9'h006, 32'h0, 1'b1, a0);

    // Split halfword across words 4 and 5.
    do_req(1'b1, 3'd0, 9'h010, 32'h11223344, 1'b1, a0);
    do_req(1'b1, 3'd0, 9'h014, 32'h55667788, 1'b1, a0);
    do_req(1'b0, 3'd1, 9'h013, 32'h0, 1'b1, a0);
    check_val("lh_acc0_waddr", 32'(mem_waddr), 32'd4);
    check_val("lh_acc0_be", 32'(mem_be), 32'h8);
    check_val("lh_acc0_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    check_val("lh_acc1_state", 32'(dbg_state), 32'd2);
    check_val("lh_acc1_waddr", 32'(mem_waddr), 32'd5);
    check_val("lh_acc1_be", 32'(mem_be), 32'h1);
    do_req(1'b0, 3'd2, 9'h013, 32'h0, 1'b1, a0);

    // Split word store wrapping from the top word to word 0.
    do_req(1'b1, 3'd0, 9'h1FE, 32'hAABBCCDD, 1'b1, a0);
    check_val("wrap_acc0_waddr", 32'(mem_waddr), 32'd127);
    check_val("wrap_acc0_be", 32'(mem_be), 32'hC);
    check_val("wrap_acc0_wdata", mem_wdata, 32'hCCDD0000);
    @(negedge clk);
    check_val("wrap_acc1_waddr", 32'(mem_waddr), 32'd0);
    check_val("wrap_acc1_be", 32'(mem_be), 32'h3);
    check_val("wrap_acc1_wdata", mem_wdata, 32'h0000AABB);
    do_req(1'b0, 3'd0, 9'h1FE, 32'h0, 1'b1, a0);

    // Busy: second request raised during ACC0 waits for req_ready.
    do_req(1'b0, 3'd0, 9'h010, 32'h0, 1'b1, a0);
    check_val("busy_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b1; req_we = 1'b0; req_type = 3'd1; req_addr = 9'h012;
    do_req(1'b0, 3'd1, 9'h012, 32'h0, 1'b1, a1);
    check_val("busy_accept_cycle", 32'(a1), 32'(a0 + 3));

    // Invalid type: no memory access, zero result.
    do_req(1'b1, 3'd7, 9'h020, 32'hFFFFFFFF, 1'b1, a0);
    check_val("inv_mem_en", 32'(mem_en), 32'd0);
    do_req(1'b0, 3'd5, 9'h020, 32'h0, 1'b1, a0);

    // Reset during ACC0 of a split store: nothing written, no response.
    do_req(1'b1, 3'd0, 9'h011, 32'hCAFEF00D, 1'b0, a0);
    rstn = 1'b0;
    #1;
    check_val("midrst_mem_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_val("midrst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check_val("midrst_idle", 32'(dbg_state), 32'd0);
    check_val("midrst_word5", tb_mem[5], 32'h55667788);
    do_req(1'b0, 3'd0, 9'h014, 32'h0, 1'b1, a0);
    do_req(1'b0, 3'd0, 9'h010, 32'h0, 1'b1, a0);

    // Random mix of widths, offsets, loads, stores and invalid types.
    for (int n = 0; n < 80; n++) begin
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             AW'($urandom_range(0, NB - 1)), $urandom, 1'b1, a0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check_val("drain", 32'(exp_q.size()), 32'd0);

    for (int w = 0; w < NW; w++)
      check_val($sformatf("mem_word_%0d", w), tb_mem[w],
                {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Memory-stage load/store initiator. Accepts one load/store request per transaction from the pipeline and drives a word-organised, byte-enabled data memory port.
- Memory port has a synchronous 1-cycle read.
- Handles all RV32 widths and offsets, including misaligned halfword/word accesses that cross a word boundary; these are split into two word accesses.
- Provides a ready/response handshake so the hazard unit can stall the pipeline.

Parameters:
- AW, 9, byte-address width; word index is AW-2 bits.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- req_we  in  1  1=store, 0=load
- req_type  in  3  width code: 000 word, 001 halfword, 010 halfword unsigned, 011 byte, 100 byte unsigned; 101-111 invalid
- req_addr  in  AW  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse (loads and stores)
- rsp_rdata  out  32  extended load result; 0 for stores, invalid types, and when rsp_valid=0
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write strobe, qualified by mem_en
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian)
- mem_waddr  out  AW-2  word index
- mem_wdata  out  32  lane-positioned write data
- mem_rdata  in  32  word read in the previous cycle

Behaviour:
- FSM states: IDLE, ACC0, ACC1, RESP. Reset state is IDLE.
- Reset values: req_ready=1; rsp_valid=0; rsp_rdata=0; mem_en=0; mem_we=0; mem_be=0; mem_waddr=0; mem_wdata=0; internal registers 0.
- While rstn=0, all mem_* outputs are forced to 0 combinationally, so no write occurs in the reset cycle.
- req_ready = (state==IDLE).
- On accept, latch we, type, addr and wdata, then go to ACC0. Requests made while not IDLE are ignored; the requester holds them.
- Let off=addr[1:0] and N=addr[AW-1:2].
- Split access occurs for: halfword with off=3; word with off!=0. Bytes never split.
- ACC0:
  - Drive word N with lane-shifted data/enables:
    - byte: be=0001<<off
    - halfword: be=0011<<off
    - word: be=1111<<off, truncated to 4 bits
  - wdata = req_wdata << 8*off.
  - If split, go to ACC1; else go to RESP.
- ACC1:
  - Drive word N+1, computed modulo 2^(AW-2), so the top word wraps to 0.
  - Enables are the remaining low lanes: halfword off3 → 0001; word off1 → 0001, off2 → 0011, off3 → 0111.
  - wdata = req_wdata >> 8*(4-off).
  - Capture mem_rdata (word N) into a hold register. Go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, then return to IDLE.
  - Load result is assembled from the hold register (low bytes) and mem_rdata (last word read), then:
    - sign-extended for types 000/001/011
    - zero-extended for types 010/100
- mem_we = mem_en && latched we.
- Loads use mem_we=0, but mem_be still shows the lanes used.
- Latency from accept cycle T:
  - unsplit: mem access T+1, rsp_valid T+2, next accept T+3
  - split: accesses T+1 and T+2, rsp_valid T+3, next accept T+4
- Invalid type: no memory access (mem_en stays 0 in ACC0). Go straight to RESP with rsp_rdata=0.
- Reset mid-transaction (any state): next state IDLE. A pending second write half is never issued, and no rsp_valid is produced.
- Stores return rsp_rdata=0.

Test Plan:
- Aligned word: sw addr 0x010 data 0xDEADBEEF → T+1: mem_en=1, we=1, be=1111, waddr=4, wdata=0xDEADBEEF; T+2: rsp_valid=1. Then lw 0x010 → rsp_rdata=0xDEADBEEF at T+2.
- Byte extension: sb 0x82 at addr 0x006 → be=0100, wdata=0x00820000. Then lb 0x006 → 0xFFFFFF82; lbu 0x006 → 0x00000082.
- Split halfword: word4=0x11223344, word5=0x55667788; lh addr 0x013 → ACC0 waddr=4 be=1000, ACC1 waddr=5 be=0001, rsp_rdata=0xFFFF8811 at T+3. lhu → 0x00008811.
- Split word with wrap: sw addr 0x1FE (AW=9) data 0xAABBCCDD → ACC0 waddr=127 be=1100 wdata=0xCCDD0000; ACC1 waddr=0 be=0011 wdata=0x0000AABB; rsp_valid at T+3.
- Busy and invalid: second req_valid held during ACC0 is not accepted until req_ready=1. req_type=111 → no mem_en, rsp_valid at T+2 with rsp_rdata=0.
- Reset mid-split: assert rstn=0 during ACC0 of split sw 0x011 → word 5 never written, no rsp_valid, req_ready=1 after release.
